uart_tx_ctrl: RTL and testbench

UART transmit stage that drains the 8-bit `fifo` on its pop side and serializes each byte as an 8N1 frame on a single TX line. It sits directly downstream of the TX FIFO. It watches `empty`, samples the show-ahead `pop_data`, and issues one-cycle `pop` strobes. Back-to-back bytes go out with no idle gap, so the FIFO is the only rate-matching buffer between the producer and the wire.

---
 rtl/uart_tx_ctrl.sv | 112 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter that drains a show-ahead FIFO and serializes bytes LSB first.
// Back-to-back bytes are popped in the final stop-bit cycle, so frames follow with no idle gap.
module uart_tx_ctrl #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_ctrl: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic          bit_end;

    always_comb begin
        bit_end    = (baud_cnt_q == LAST);
        fifo_pop   = rst & ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q != 3'd7) begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[1];
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d   = IDLE;
                    tx_busy_d = 1'b0;
                    tx_d      = 1'b1;
                end
            end
            default: ;
        endcase

        // A pop (from IDLE or the last stop cycle) overrides the STOP->IDLE fall-through.
        if (fifo_pop) begin
            shreg_d    = fifo_data;
            state_d    = START;
            baud_cnt_d = '0;
            tx_d       = 1'b0;
            tx_busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl at DIV=4: cycle-by-cycle vector table plus FIFO-fed multi-frame sequences.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       drv_empty = 1'b1;
    logic [7:0] drv_data = '0;
    logic       use_fifo = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;

    logic [7:0] fmem [16];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLK_HZ(100), .BAUD(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    // Show-ahead FIFO model used for the multi-frame sequences.
    always_comb begin
        fifo_empty = use_fifo ? (wr_ptr == rd_ptr) : drv_empty;
        fifo_data  = use_fifo ? fmem[rd_ptr] : drv_data;
    end

    always @(posedge clk) begin
        if (use_fifo && fifo_pop && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 4'd1;
    end

    typedef struct {
        logic        empty;
        logic [7:0]  data;
        int unsigned n;
        logic [2:0]  exp;   // {fifo_pop, tx, tx_busy}
    } vec_t;

    vec_t tbl[$];

    function void add(input logic e, input logic [7:0] d, input int unsigned n, input logic [2:0] x);
        vec_t v;
        v.empty = e;
        v.data  = d;
        v.n     = n;
        v.exp   = x;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] exp);
        checks++;
        if ({fifo_pop, tx, tx_busy} !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: {pop,tx,busy} got %b expected %b at %0t",
                     name, idx, {fifo_pop, tx, tx_busy}, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Expected {pop,tx,busy} at cycle c of n back-to-back frames whose first pop is cycle 0.
    function automatic logic [2:0] exp_at(input int c, input int n, input logic [23:0] bytes);
        int p, f, slot;
        logic [7:0] b;
        logic t;
        if (c == 0) return 3'b110;
        if (c > 40 * n) return 3'b010;
        p = (c - 1) % 40;
        f = (c - 1) / 40;
        slot = p / 4;
        b = bytes[f*8 +: 8];
        if (slot == 0) t = 1'b0;
        else if (slot == 9) t = 1'b1;
        else t = b[slot-1];
        return {(p == 39) && (f < n - 1), t, 1'b1};
    endfunction

    task automatic run_frames(input logic [23:0] bytes, input int n, input int ncyc,
                              input string name, output int pops);
        pops = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check(name, c, exp_at(c, n, bytes));
            if (fifo_pop) pops++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;

        // 0xA5 alone, FIFO drains right after the pop.
        add(1'b0, 8'hA5, 1, 3'b110);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 3, 3'b010);
        // 0x00 then 0xFF back to back; 0xFF waits visibly during the first frame.
        add(1'b0, 8'h00, 1, 3'b110);
        add(1'b0, 8'hFF, 4, 3'b001);
        add(1'b0, 8'hFF, 32, 3'b001);
        add(1'b0, 8'hFF, 3, 3'b011);
        add(1'b0, 8'hFF, 1, 3'b111);
        add(1'b1, 8'h00, 4, 3'b001);
        add(1'b1, 8'h00, 32, 3'b011);
        add(1'b1, 8'h00, 4, 3'b011);
        add(1'b1, 8'h00, 2, 3'b010);
        // 0x5A with data available mid-frame but empty rising exactly at stop bit_end.
        add(1'b0, 8'h5A, 1, 3'b110);
        add(1'b0, 8'hC3, 4, 3'b001);
        add(1'b0, 8'hC3, 4, 3'b001);
        add(1'b0, 8'hC3, 4, 3'b011);
        add(1'b0, 8'hC3, 4, 3'b001);
        add(1'b0, 8'hC3, 4, 3'b011);
        add(1'b0, 8'hC3, 4, 3'b011);
        add(1'b0, 8'hC3, 4, 3'b001);
        add(1'b0, 8'hC3, 4, 3'b011);
        add(1'b0, 8'hC3, 4, 3'b001);
        add(1'b0, 8'hC3, 3, 3'b011);
        add(1'b1, 8'hC3, 1, 3'b011);
        add(1'b1, 8'h00, 2, 3'b010);

        // Reset with data available: no pop, idle line.
        rst = 1'b0;
        drv_empty = 1'b0;
        drv_data = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, 3'b010);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                drv_empty = tbl[i].empty;
                drv_data  = tbl[i].data;
                @(negedge clk);
                check("vec", i, tbl[i].exp);
                @(posedge clk);
                #1;
            end
        end

        drv_empty = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drv_data = 8'($urandom);
            @(negedge clk);
            check("empty_hold", i, 3'b010);
            @(posedge clk);
            #1;
        end

        use_fifo = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        run_frames({8'h33, 8'h22, 8'h11}, 3, 122, "fifo3", pops);
        checks++;
        if (pops != 3) begin
            errors++;
            $display("FAIL fifo3_pops: got %0d pops expected 3", pops);
        end

        push(8'h3C);
        run_frames({16'h0000, 8'h3C}, 1, 18, "pre_rst", pops);
        push(8'h96);
        rst = 1'b0;
        #1;
        check("rst_mid", 0, 3'b010);
        @(posedge clk);
        #1;
        check("rst_mid", 1, 3'b010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_frames({16'h0000, 8'h96}, 1, 42, "after_rst", pops);
        checks++;
        if (pops != 1) begin
            errors++;
            $display("FAIL after_rst_pops: got %0d pops expected 1", pops);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
